// File: rtl/vram_arb_pkg.sv
// Shared types and default configuration for the VRAM arbiter.
// Anti-starvation guard is selected in vram_arbiter by VRAM_ARB_STARVE_GUARD_EN.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam int unsigned AW_DEF           = 17;
    localparam int unsigned DW_DEF           = 16;
    localparam int unsigned RD_LAT_DEF       = 2;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned LEN_W            = 4;

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-return tracker: delays each mem_re by RD_LAT cycles to mark returning beats.
// Asynchronous clear drops every beat still in flight.
module vram_rd_pipe
    import vram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic re,
    output logic valid,
    output logic inflight
);

    logic [RD_LAT-1:0] sr_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= re;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign valid    = sr_q[RD_LAT-1];
    assign inflight = |sr_q;

endmodule

// File: rtl/vram_arbiter.sv
// Two-client VRAM arbiter: display read bursts vs single-word writes, one memory port.
// Define VRAM_ARB_STARVE_GUARD_EN to let a waiting writer preempt after STARVE_LIMIT display grants.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned AW           = AW_DEF,
    parameter int unsigned DW           = DW_DEF,
    parameter int unsigned RD_LAT       = RD_LAT_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             disp_req,
    input  logic [AW-1:0]    disp_addr,
    input  logic [LEN_W-1:0] disp_len,
    output logic             disp_gnt,
    output logic [DW-1:0]    disp_rdata,
    output logic             disp_rvalid,
    input  logic             wr_req,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    output logic             wr_gnt,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beats_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             window;
    logic             wr_pick;
    logic             starve_hit;
    logic             inflight;
    logic [SW-1:0]    starve_q;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;

    // Counts display grants the writer has watched go by; a dropped wr_req forfeits the credit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_q <= '0;
        end else if (!wr_req || wr_gnt) begin
            starve_q <= '0;
        end else if (disp_gnt && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_q <= starve_q + SW'(1);
        end
    end
`else
    localparam bit GUARD_EN = 1'b0;

    assign starve_q = '0;
`endif

    assign starve_hit = GUARD_EN && (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        window   = nrst && ((state_q == IDLE) || (state_q == WR) ||
                            ((state_q == DISP) && (beats_q == '0)));
        wr_pick  = wr_req && (!disp_req || starve_hit);
        disp_gnt = window && disp_req && !wr_pick;
        wr_gnt   = window && wr_pick;

        state_d = state_q;
        if (disp_gnt) begin
            state_d = DISP;
        end else if (wr_gnt) begin
            state_d = WR;
        end else if (window) begin
            state_d = IDLE;
        end
    end

    // beats_q holds beats remaining after the current one, so zero marks the last beat.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            beats_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (disp_gnt) begin
                addr_q  <= disp_addr;
                beats_q <= disp_len;
            end else if (wr_gnt) begin
                addr_q  <= wr_addr;
                wdata_q <= wr_data;
                beats_q <= '0;
            end else if ((state_q == DISP) && (beats_q != '0)) begin
                addr_q  <= addr_q + AW'(1);
                beats_q <= beats_q - LEN_W'(1);
            end
        end
    end

    assign mem_re    = (state_q == DISP);
    assign mem_we    = (state_q == WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    vram_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk      (clk),
        .nrst     (nrst),
        .re       (mem_re),
        .valid    (disp_rvalid),
        .inflight (inflight)
    );

    assign disp_rdata = disp_rvalid ? mem_rdata : '0;
    assign busy       = (state_q != IDLE) || inflight;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level schedule of memory operations.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int AW    = AW_DEF;
    localparam int DW    = DW_DEF;
    localparam int RDL   = RD_LAT_DEF;
    localparam int LIMIT = STARVE_LIMIT_DEF;

    logic          clk;
    logic          nrst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [3:0]    disp_len;
    logic          disp_gnt;
    logic [DW-1:0] disp_rdata;
    logic          disp_rvalid;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    vram_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .RD_LAT       (RDL),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_len    (disp_len),
        .disp_gnt    (disp_gnt),
        .disp_rdata  (disp_rdata),
        .disp_rvalid (disp_rvalid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Scheduled memory operations per absolute cycle: kind 1 = read, 2 = write.
    int op_kind[int];
    int op_addr[int];
    int op_data[int];
    int free_cyc   = 0;
    int last_addr  = 0;
    int last_wdata = 0;
    int starve     = 0;

    bit d_want = 0, w_want = 0;
    int d_addr = 0, d_len = 0, w_addr = 0, w_data = 0;
    bit dg = 0, wg = 0;
    int obs_d = 0, obs_w = 0, obs_rv = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input int a);
        return DW'((a * 40503) ^ 23130);
    endfunction

    function automatic bit is_kind(input int c, input int k);
        return op_kind.exists(c) && (op_kind[c] == k);
    endfunction

    task automatic drive_inputs();
        disp_req  = d_want;
        disp_addr = AW'(d_addr);
        disp_len  = 4'(d_len);
        wr_req    = w_want;
        wr_addr   = AW'(w_addr);
        wr_data   = DW'(w_data);
    endtask

    task automatic eval_cycle();
        int  c;
        bit  win, full, edg, ewr, erv, ebusy;
        c     = cyc;
        win   = (free_cyc <= c + 1);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        full  = (starve == LIMIT);
`else
        full  = 1'b0;
`endif
        ewr   = win && w_want && (!d_want || full);
        edg   = win && d_want && !ewr;
        erv   = is_kind(c - RDL, 1);
        ebusy = op_kind.exists(c);
        for (int k = 1; k <= RDL; k++) if (is_kind(c - k, 1)) ebusy = 1'b1;
        if (op_kind.exists(c)) begin
            last_addr = op_addr[c];
            if (op_kind[c] == 2) last_wdata = op_data[c];
        end

        check_eq("disp_gnt", disp_gnt, edg);
        check_eq("wr_gnt", wr_gnt, ewr);
        check_eq("mem_re", mem_re, is_kind(c, 1));
        check_eq("mem_we", mem_we, is_kind(c, 2));
        check_eq("mem_addr", mem_addr, last_addr);
        check_eq("mem_wdata", mem_wdata, last_wdata);
        check_eq("disp_rvalid", disp_rvalid, erv);
        check_eq("busy", busy, ebusy);
        if (erv) check_eq("disp_rdata", disp_rdata, mem_word(op_addr[c - RDL]));

        obs_d  += int'(disp_gnt);
        obs_w  += int'(wr_gnt);
        obs_rv += int'(disp_rvalid);

        if (edg) begin
            for (int i = 0; i <= d_len; i++) begin
                op_kind[c + 1 + i] = 1;
                op_addr[c + 1 + i] = (d_addr + i) % (1 << AW);
            end
            free_cyc = c + 2 + d_len;
        end
        if (ewr) begin
            op_kind[c + 1] = 2;
            op_addr[c + 1] = w_addr;
            op_data[c + 1] = w_data;
            free_cyc = c + 2;
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        if (!w_want || ewr) starve = 0;
        else if (edg && starve < LIMIT) starve++;
`endif
        if (op_kind.exists(c - RDL - 1)) op_kind.delete(c - RDL - 1);
        dg = edg;
        wg = ewr;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step();
        drive_inputs();
        if (is_kind(cyc - RDL, 1)) mem_rdata = mem_word(op_addr[cyc - RDL]);
        else                       mem_rdata = DW'($urandom);
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (dg) d_want = 0;
        if (wg) w_want = 0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Asserts reset mid-cycle, then releases on a falling edge so the next rising edge may grant.
    task automatic do_reset(input int n);
        nrst = 1'b0;
        drive_inputs();
        op_kind.delete();
        op_addr.delete();
        op_data.delete();
        free_cyc = 0; last_addr = 0; last_wdata = 0; starve = 0;
        #1;
        check_eq("rst_mem_re", mem_re, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        check_eq("rst_disp_gnt", disp_gnt, 1'b0);
        check_eq("rst_wr_gnt", wr_gnt, 1'b0);
        check_eq("rst_rvalid", disp_rvalid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_rdata", disp_rdata, 0);
        repeat (n) @(posedge clk);
        cyc += n;
        @(negedge clk);
        nrst = 1'b1;
        mem_rdata = DW'($urandom);
        #1;
        eval_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (dg) d_want = 0;
        if (wg) w_want = 0;
    endtask

    initial begin
        nrst = 1'b0;
        mem_rdata = '0;
        drive_inputs();
        @(posedge clk);
        #1;
        cyc = 1;

        // Single burst granted on the first edge after reset release.
        d_want = 1; d_addr = 'h00100; d_len = 3;
        obs_d = 0; obs_rv = 0;
        do_reset(2);
        run(8);
        check_eq("burst_grants", obs_d, 1);
        check_eq("burst_beats", obs_rv, 4);

        // Address wrap at the top of memory.
        d_want = 1; d_addr = 'h1FFFE; d_len = 3;
        obs_rv = 0;
        run(9);
        check_eq("wrap_beats", obs_rv, 4);

        // Both request from IDLE: display first, writer in the last-beat cycle.
        d_want = 1; d_addr = 'h00040; d_len = 2;
        w_want = 1; w_addr = 'h00055; w_data = 'hBEEF;
        obs_d = 0; obs_w = 0;
        run(10);
        check_eq("both_disp", obs_d, 1);
        check_eq("both_wr", obs_w, 1);

        // Two single-beat bursts back to back.
        d_want = 1; d_addr = 'h00010; d_len = 0;
        step();
        d_want = 1; d_addr = 'h00020; d_len = 0;
        run(6);

        // Writer waiting behind a continuous display stream.
        obs_d = 0; obs_w = 0;
        w_want = 1; w_addr = 'h00777; w_data = 'h1234;
        for (int i = 0; i < 20; i++) begin
            d_want = 1; d_addr = 'h00500 + i; d_len = 0;
            step();
            if (wg) break;
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        check_eq("starve_disp", obs_d, LIMIT);
        check_eq("starve_wr", obs_w, 1);
`else
        check_eq("starve_disp", obs_d, 20);
        check_eq("starve_wr", obs_w, 0);
`endif
        d_want = 0;
        run(8);

        // Reset during beat 2 of a 16-beat burst.
        d_want = 1; d_addr = 'h00300; d_len = 15;
        step();
        step();
        step();
        check_eq("pre_rst_re", mem_re, 1'b1);
        d_want = 0; w_want = 0;
        do_reset(2);
        obs_rv = 0;
        run(8);
        check_eq("post_rst_rvalid", obs_rv, 0);

        // Random traffic with drops and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (!d_want) begin
                if ($urandom_range(2) == 0) begin
                    d_want = 1;
                    d_addr = int'($urandom_range((1 << AW) - 1));
                    d_len  = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : int'($urandom_range(2));
                end
            end else if ($urandom_range(15) == 0) begin
                d_want = 0;
            end
            if (!w_want) begin
                if ($urandom_range(2) == 0) begin
                    w_want = 1;
                    w_addr = int'($urandom_range((1 << AW) - 1));
                    w_data = int'($urandom_range((1 << DW) - 1));
                end
            end else if ($urandom_range(15) == 0) begin
                w_want = 0;
            end
            if (i % 1000 == 999) do_reset(int'($urandom_range(3, 1)));
            else                 step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
